// File: rtl/fifo_tx_ctrl_pkg.sv
// Shared definitions for the TX FIFO read-side controller: state encoding,
// default parameter values and counter sizing helpers.
package fifo_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_GAP   = 3'd5
  } tx_state_e;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_RD_LATENCY     = 1;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_CNT_WIDTH      = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold values 0..maxv, never less than one.
  function automatic int cnt_bits(input int maxv);
    return (maxv <= 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/fifo_tx_ctrl_cycle_counter.sv
// Loadable down-counter with a zero flag; shared by the FETCH, SEND-timeout
// and GAP phases since only one of them is ever active.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_tx_ctrl.sv
// Pops the TX FIFO one byte at a time and offers each byte to UART_TX with a
// valid/busy handshake, handling stalls, enable gating and a handshake timeout.
module fifo_tx_ctrl
  import fifo_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_EN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  input  logic                  CLR_TIMEOUT,
  output logic                  TX_TIMEOUT,
  output logic [CNT_WIDTH-1:0]  BYTE_CNT
);

  // Counter loads are "cycles minus one": the phase ends on the cycle the count reads zero.
  localparam int LAT_LD = RD_LATENCY - 1;
  localparam int GAP_LD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LD  = TIMEOUT_CYCLES - 1;
  localparam int CW     = cnt_bits(max3(LAT_LD, GAP_LD, TO_LD));

  localparam logic [CW-1:0] LAT_V = CW'(LAT_LD);
  localparam logic [CW-1:0] GAP_V = CW'(GAP_LD);
  localparam logic [CW-1:0] TO_V  = CW'(TO_LD);

  tx_state_e     state, nxt;
  logic          cc_load, cc_dec, cc_zero;
  logic [CW-1:0] cc_val;
  logic          latch, cnt_inc, to_set;

  cycle_counter #(.W(CW)) u_cc (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cc_load),
    .load_val (cc_val),
    .dec      (cc_dec),
    .zero     (cc_zero)
  );

  always_comb begin
    nxt     = state;
    cc_load = 1'b0;
    cc_dec  = 1'b0;
    cc_val  = '0;
    latch   = 1'b0;
    cnt_inc = 1'b0;
    to_set  = 1'b0;
    case (state)
      ST_IDLE: if (TX_EN && !FIFO_EMPTY && !TX_BUSY) nxt = ST_POP;
      ST_POP: begin
        nxt     = ST_FETCH;
        cc_load = 1'b1;
        cc_val  = LAT_V;
      end
      ST_FETCH: begin
        if (cc_zero) begin
          latch   = 1'b1;
          nxt     = ST_SEND;
          cc_load = 1'b1;
          cc_val  = TO_V;
        end else cc_dec = 1'b1;
      end
      // Busy takes priority over an expiring timeout on the same edge.
      ST_SEND: begin
        if (TX_BUSY) nxt = ST_DRAIN;
        else if (cc_zero) begin
          to_set = 1'b1;
          nxt    = ST_IDLE;
        end else cc_dec = 1'b1;
      end
      ST_DRAIN: begin
        if (!TX_BUSY) begin
          cnt_inc = 1'b1;
          if (GAP_CYCLES > 0) begin
            nxt     = ST_GAP;
            cc_load = 1'b1;
            cc_val  = GAP_V;
          end else nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cc_zero) nxt = ST_IDLE;
        else         cc_dec = 1'b1;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they are clean Moore signals.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      RD_INC        <= 1'b0;
      TX_DATA_VALID <= 1'b0;
      TX_P_DATA     <= '0;
      TX_TIMEOUT    <= 1'b0;
      BYTE_CNT      <= '0;
    end else begin
      state         <= nxt;
      RD_INC        <= (nxt == ST_POP);
      TX_DATA_VALID <= (nxt == ST_SEND);
      if (latch) TX_P_DATA <= RD_DATA;
      if (to_set)           TX_TIMEOUT <= 1'b1;
      else if (CLR_TIMEOUT) TX_TIMEOUT <= 1'b0;
      if (cnt_inc) BYTE_CNT <= BYTE_CNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_tx_ctrl.sv
// Bench for fifo_tx_ctrl: queue-based FIFO and UART models plus a scoreboard of
// expected bytes and completion count. Counter is built 4 bits wide so wrap is reachable.
module tb_fifo_tx_ctrl;

  localparam int DW = 8, LAT = 1, GAP = 2, TO = 16, CW = 4;

  logic          CLK = 1'b0, RST = 1'b1, TX_EN = 1'b0, CLR_TIMEOUT = 1'b0;
  logic          FIFO_EMPTY, TX_BUSY, RD_INC, TX_DATA_VALID, TX_TIMEOUT;
  logic [DW-1:0] RD_DATA = '0, TX_P_DATA;
  logic [CW-1:0] BYTE_CNT;

  fifo_tx_ctrl #(
    .DATA_WIDTH(DW), .RD_LATENCY(LAT), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .TX_EN(TX_EN), .FIFO_EMPTY(FIFO_EMPTY),
    .RD_DATA(RD_DATA), .RD_INC(RD_INC), .TX_BUSY(TX_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .CLR_TIMEOUT(CLR_TIMEOUT), .TX_TIMEOUT(TX_TIMEOUT), .BYTE_CNT(BYTE_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [7:0] fifo_q[$], exp_q[$], rx_q[$];
  int fifo_n = 0, exp_cnt = 0, underflow = 0;

  // UART model state
  logic busy_m = 1'b0, force_busy = 1'b0;
  bit   uart_auto = 1'b1, rnd_timing = 1'b0;
  int   dly = 0, bleft = 0, done_cnt = 0;

  // Monitor state
  int cyc = 0, rd_inc_cnt = 0, last_rd_cyc = 0, vrun = 0, last_vrun = 0;
  int lat_min = 999, lat_max = 0, dmin = 999, dmax = 0, low_cyc = 0, busy_pop_err = 0;
  bit armed = 1'b0, prev_busy = 1'b0, to_seen = 1'b0;

  assign FIFO_EMPTY = (fifo_n == 0);
  assign TX_BUSY    = busy_m | force_busy;

  // FIFO: pops mid-cycle while RD_INC is high, data ready well before the latch edge.
  always @(negedge CLK) begin
    if (RD_INC === 1'b1) begin
      if (fifo_n == 0) underflow++;
      else begin
        RD_DATA = fifo_q.pop_front();
        fifo_n--;
      end
    end
  end

  // UART_TX: accepts the offered byte (optionally after a delay) and stays busy a while.
  always @(negedge CLK) begin
    if (busy_m) begin
      if (bleft > 1) bleft--;
      else begin
        busy_m = 1'b0;
        done_cnt++;
      end
    end else if (uart_auto && TX_DATA_VALID === 1'b1) begin
      if (dly > 0) dly--;
      else begin
        rx_q.push_back(TX_P_DATA);
        busy_m = 1'b1;
        bleft  = rnd_timing ? int'($urandom_range(3, 12)) : 10;
      end
    end else dly = rnd_timing ? int'($urandom_range(0, 3)) : 0;
  end

  always begin
    @(posedge CLK); #1;
    cyc++;
    if (RD_INC === 1'b1) begin
      rd_inc_cnt++;
      last_rd_cyc = cyc;
      if (TX_BUSY) busy_pop_err++;
      if (armed) begin
        armed = 1'b0;
        if (cyc - low_cyc < dmin) dmin = cyc - low_cyc;
        if (cyc - low_cyc > dmax) dmax = cyc - low_cyc;
      end
    end
    if (TX_DATA_VALID === 1'b1) begin
      if (vrun == 0) begin
        if (cyc - last_rd_cyc < lat_min) lat_min = cyc - last_rd_cyc;
        if (cyc - last_rd_cyc > lat_max) lat_max = cyc - last_rd_cyc;
      end
      vrun++;
    end else if (vrun != 0) begin
      last_vrun = vrun;
      vrun = 0;
    end
    if (prev_busy && !TX_BUSY) begin
      armed   = 1'b1;
      low_cyc = cyc;
    end
    prev_busy = TX_BUSY;
    if (TX_TIMEOUT === 1'b1) to_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_n++;
  endtask

  task automatic wait_done(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset;
    tick(3);
    n_cmp++; if (RD_INC !== 1'b0) begin n_err++; $display("FAIL rst_rd_inc: got %b want 0", RD_INC); end
    n_cmp++; if (TX_DATA_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", TX_DATA_VALID); end
    n_cmp++; if (TX_P_DATA !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", TX_P_DATA); end
    n_cmp++; if (TX_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", TX_TIMEOUT); end
    n_cmp++; if (BYTE_CNT !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", BYTE_CNT); end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    int r0, d0;
    bit ok;
    uart_auto = 1'b1; rnd_timing = 1'b0; TX_EN = 1'b1;
    r0 = rd_inc_cnt; d0 = done_cnt; lat_min = 999; lat_max = 0;
    push(8'hA5);
    wait_done(d0 + 1, 100, ok);
    tick(GAP + 3);
    exp_cnt++;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_done: got %0d completions want %0d", done_cnt - d0, 1); end
    n_cmp++; if (rd_inc_cnt - r0 !== 1) begin n_err++; $display("FAIL single_rd_inc: got %0d pulses want 1", rd_inc_cnt - r0); end
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_err++; $display("FAIL single_byte: got %0d bytes first %h want 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    rx_q.delete(); exp_q.delete();
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL single_cnt: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
    n_cmp++; if (lat_min !== LAT + 1 || lat_max !== LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d..%0d want %0d", lat_min, lat_max, LAT + 1); end
  endtask

  task automatic test_back_to_back;
    int r0, d0, bad;
    bit ok;
    uart_auto = 1'b1; rnd_timing = 1'b1; TX_EN = 1'b1;
    r0 = rd_inc_cnt; d0 = done_cnt; bad = 0;
    armed = 1'b0; dmin = 999; dmax = 0; lat_min = 999; lat_max = 0; busy_pop_err = 0;
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    wait_done(d0 + 8, 800, ok);
    tick(GAP + 3);
    exp_cnt += 8;
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %0d completions want 8", done_cnt - d0); end
    n_cmp++; if (rd_inc_cnt - r0 !== 8) begin n_err++; $display("FAIL b2b_rd_inc: got %0d pulses want 8", rd_inc_cnt - r0); end
    if (rx_q.size() != exp_q.size()) bad++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      if (rx_q[0] !== exp_q[0]) bad++;
      void'(rx_q.pop_front()); void'(exp_q.pop_front());
    end
    rx_q.delete(); exp_q.delete();
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_order: got %0d bad bytes want 0", bad); end
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL b2b_cnt: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
    n_cmp++; if (busy_pop_err !== 0) begin n_err++; $display("FAIL b2b_pop_busy: got %0d pops while busy want 0", busy_pop_err); end
    n_cmp++; if (dmin !== GAP + 1 || dmax !== GAP + 1) begin n_err++; $display("FAIL b2b_gap: got %0d..%0d want %0d", dmin, dmax, GAP + 1); end
    n_cmp++; if (lat_min !== LAT + 1 || lat_max !== LAT + 1) begin n_err++; $display("FAIL b2b_latency: got %0d..%0d want %0d", lat_min, lat_max, LAT + 1); end
  endtask

  task automatic test_timeout;
    int r0;
    bit ok, sv;
    uart_auto = 1'b0; TX_EN = 1'b1; r0 = rd_inc_cnt;
    push(8'h7E);
    ok = 1'b0; sv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (TX_DATA_VALID === 1'b1) sv = 1'b1;
      else if (sv) begin ok = 1'b1; break; end
    end
    tick(2);
    void'(exp_q.pop_front());
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL to_end: got valid_seen=%b still=%b want drop", sv, TX_DATA_VALID); end
    n_cmp++; if (last_vrun !== TO) begin n_err++; $display("FAIL to_valid_len: got %0d want %0d", last_vrun, TO); end
    n_cmp++; if (TX_TIMEOUT !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", TX_TIMEOUT); end
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL to_cnt: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
    n_cmp++; if (rd_inc_cnt - r0 !== 1) begin n_err++; $display("FAIL to_rd_inc: got %0d want 1", rd_inc_cnt - r0); end
    CLR_TIMEOUT = 1'b1; tick(1); CLR_TIMEOUT = 1'b0;
    n_cmp++; if (TX_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", TX_TIMEOUT); end
    // Hold clear through a second timeout: the set must still show up.
    CLR_TIMEOUT = 1'b1; to_seen = 1'b0;
    push(8'h42);
    sv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (TX_DATA_VALID === 1'b1) sv = 1'b1;
      else if (sv) break;
    end
    tick(1);
    CLR_TIMEOUT = 1'b0;
    void'(exp_q.pop_front());
    n_cmp++; if (to_seen !== 1'b1) begin n_err++; $display("FAIL to_set_wins: got %b want 1", to_seen); end
    n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL to_no_accept: got %0d bytes want 0", rx_q.size()); end
    CLR_TIMEOUT = 1'b1; tick(1); CLR_TIMEOUT = 1'b0; tick(1);
  endtask

  task automatic test_enable;
    int r0, d0, bad;
    bit ok1, ok2;
    uart_auto = 1'b1; rnd_timing = 1'b0; TX_EN = 1'b0;
    r0 = rd_inc_cnt; d0 = done_cnt; bad = 0;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    tick(50);
    n_cmp++; if (rd_inc_cnt - r0 !== 0) begin n_err++; $display("FAIL en_off: got %0d pops want 0", rd_inc_cnt - r0); end
    TX_EN = 1'b1;
    ok1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (TX_BUSY && TX_DATA_VALID === 1'b0) begin ok1 = 1'b1; break; end
    end
    TX_EN = 1'b0;
    wait_done(d0 + 1, 60, ok2);
    tick(20);
    exp_cnt++;
    n_cmp++; if ((ok1 & ok2) !== 1'b1) begin n_err++; $display("FAIL en_drain: got drain=%b done=%b want 1 1", ok1, ok2); end
    n_cmp++; if (rd_inc_cnt - r0 !== 1) begin n_err++; $display("FAIL en_one_pop: got %0d want 1", rd_inc_cnt - r0); end
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL en_cnt: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
    n_cmp++; if (fifo_n !== 2) begin n_err++; $display("FAIL en_left: got %0d bytes in fifo want 2", fifo_n); end
    TX_EN = 1'b1;
    wait_done(d0 + 3, 200, ok2);
    tick(GAP + 3);
    exp_cnt += 2;
    if (!ok2 || rx_q.size() != exp_q.size()) bad++;
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      if (rx_q[0] !== exp_q[0]) bad++;
      void'(rx_q.pop_front()); void'(exp_q.pop_front());
    end
    rx_q.delete(); exp_q.delete();
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL en_order: got %0d bad want 0", bad); end
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL en_cnt2: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
  endtask

  task automatic test_busy_idle;
    int r0, d0;
    bit ok;
    TX_EN = 1'b1; force_busy = 1'b1; r0 = rd_inc_cnt; d0 = done_cnt;
    push(8'hC3);
    tick(20);
    n_cmp++; if (rd_inc_cnt - r0 !== 0) begin n_err++; $display("FAIL busy_hold: got %0d pops want 0", rd_inc_cnt - r0); end
    force_busy = 1'b0;
    wait_done(d0 + 1, 100, ok);
    tick(GAP + 3);
    exp_cnt++;
    n_cmp++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hC3) begin
      n_err++; $display("FAIL busy_release: got done=%b %0d bytes want 1 byte c3", ok, rx_q.size());
    end
    rx_q.delete(); exp_q.delete();
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL busy_cnt: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
  endtask

  task automatic test_reset_mid;
    int r0, d0;
    bit ok;
    uart_auto = 1'b0; TX_EN = 1'b1;
    push(8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (TX_DATA_VALID === 1'b1) begin ok = 1'b1; break; end
    end
    RST = 1'b1; tick(1);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmid_send: got valid=%b want 1 before reset", ok); end
    n_cmp++; if (TX_DATA_VALID !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", TX_DATA_VALID); end
    n_cmp++; if (RD_INC !== 1'b0) begin n_err++; $display("FAIL rmid_rd_inc: got %b want 0", RD_INC); end
    n_cmp++; if (BYTE_CNT !== '0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", BYTE_CNT); end
    RST = 1'b0;
    exp_cnt = 0; void'(exp_q.pop_front());
    r0 = rd_inc_cnt;
    tick(20);
    n_cmp++; if (rd_inc_cnt - r0 !== 0) begin n_err++; $display("FAIL rmid_no_repop: got %0d want 0", rd_inc_cnt - r0); end
    uart_auto = 1'b1; d0 = done_cnt;
    push(8'h3C);
    wait_done(d0 + 1, 100, ok);
    tick(GAP + 3);
    exp_cnt++;
    n_cmp++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      n_err++; $display("FAIL rmid_resume: got done=%b %0d bytes want 1 byte 3c", ok, rx_q.size());
    end
    rx_q.delete(); exp_q.delete();
    n_cmp++; if (BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL rmid_cnt2: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
  endtask

  task automatic test_wrap;
    int m, d0;
    bit ok;
    uart_auto = 1'b1; rnd_timing = 1'b1; TX_EN = 1'b1;
    m = 15 - (exp_cnt % 16); d0 = done_cnt;
    for (int i = 0; i < m; i++) push(8'($urandom));
    wait_done(d0 + m, 400, ok);
    tick(GAP + 3);
    exp_cnt += m;
    n_cmp++; if (!ok || BYTE_CNT !== 4'hF) begin n_err++; $display("FAIL wrap_full: got %0d want 15", BYTE_CNT); end
    push(8'($urandom));
    wait_done(d0 + m + 1, 100, ok);
    tick(GAP + 3);
    exp_cnt++;
    n_cmp++; if (!ok || BYTE_CNT !== CW'(exp_cnt)) begin n_err++; $display("FAIL wrap_zero: got %0d want %0d", BYTE_CNT, CW'(exp_cnt)); end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_no_underflow;
    n_cmp++; if (underflow !== 0) begin n_err++; $display("FAIL underflow: got %0d empty pops want 0", underflow); end
    n_cmp++; if (fifo_n !== 0) begin n_err++; $display("FAIL fifo_left: got %0d want 0", fifo_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_enable();
    test_busy_idle();
    test_reset_mid();
    test_wrap();
    test_no_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by cycle %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
